// File: rtl/axi_read_arbiter_rr_pkg.sv
// Shared definitions for the round-robin AXI read router: FSM state
// encodings, AXI field widths, the default master-1 base address and a
// couple of small helpers used by the datapath.
package axi_defs;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_LEN_WIDTH  = 8;

   localparam logic [AXI_ADDR_WIDTH-1:0] M1_BASE_ADDRESS_DEFAULT = 32'h1000_0000;

   typedef enum logic [1:0] {
      STATE_ARBITRATE     = 2'd0,
      STATE_ISSUE_ADDRESS = 2'd1,
      STATE_ACTIVE_BURST  = 2'd2
   } state_e;

   // AXI ARLEN encodes beats-1; widen by one bit so ARLEN=255 gives 256.
   function automatic logic [AXI_LEN_WIDTH:0] beats_from_len(input logic [AXI_LEN_WIDTH-1:0] len);
      return {1'b0, len} + 9'd1;
   endfunction

   // Addresses forwarded to master 1 are relative to its base.
   function automatic logic [AXI_ADDR_WIDTH-1:0] rebase_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                             input logic [AXI_ADDR_WIDTH-1:0] base);
      return addr - base;
   endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_if.sv
// Bundles the requestor-side and downstream-side read-channel signals of
// the round-robin router. Modport "slave" is the router's view (it is the
// slave of the requestors); modport "master" is the surrounding system.
interface axi_read_arbiter_rr_if #(
   parameter int NUM_SLAVES = 3,
   parameter int DATA_WIDTH = 32
);
   import axi_defs::*;

   // requestor side
   logic [NUM_SLAVES*AXI_ADDR_WIDTH-1:0] axi_araddr_s;
   logic [NUM_SLAVES*AXI_LEN_WIDTH-1:0]  axi_arlen_s;
   logic [NUM_SLAVES-1:0]                axi_arvalid_s;
   logic [NUM_SLAVES-1:0]                axi_arready_s;
   logic [NUM_SLAVES-1:0]                axi_rready_s;
   logic [NUM_SLAVES-1:0]                axi_rvalid_s;
   logic [NUM_SLAVES-1:0]                axi_rlast_s;
   logic [DATA_WIDTH-1:0]                axi_rdata_s;

   // downstream master 0
   logic [AXI_ADDR_WIDTH-1:0] axi_araddr_m0;
   logic [AXI_LEN_WIDTH-1:0]  axi_arlen_m0;
   logic                      axi_arvalid_m0;
   logic                      axi_arready_m0;
   logic                      axi_rvalid_m0;
   logic                      axi_rready_m0;
   logic [DATA_WIDTH-1:0]     axi_rdata_m0;

   // downstream master 1
   logic [AXI_ADDR_WIDTH-1:0] axi_araddr_m1;
   logic [AXI_LEN_WIDTH-1:0]  axi_arlen_m1;
   logic                      axi_arvalid_m1;
   logic                      axi_arready_m1;
   logic                      axi_rvalid_m1;
   logic                      axi_rready_m1;
   logic [DATA_WIDTH-1:0]     axi_rdata_m1;

   modport slave (
      input  axi_araddr_s, axi_arlen_s, axi_arvalid_s, axi_rready_s,
      input  axi_arready_m0, axi_rvalid_m0, axi_rdata_m0,
      input  axi_arready_m1, axi_rvalid_m1, axi_rdata_m1,
      output axi_arready_s, axi_rvalid_s, axi_rlast_s, axi_rdata_s,
      output axi_araddr_m0, axi_arlen_m0, axi_arvalid_m0, axi_rready_m0,
      output axi_araddr_m1, axi_arlen_m1, axi_arvalid_m1, axi_rready_m1
   );

   modport master (
      output axi_araddr_s, axi_arlen_s, axi_arvalid_s, axi_rready_s,
      output axi_arready_m0, axi_rvalid_m0, axi_rdata_m0,
      output axi_arready_m1, axi_rvalid_m1, axi_rdata_m1,
      input  axi_arready_s, axi_rvalid_s, axi_rlast_s, axi_rdata_s,
      input  axi_araddr_m0, axi_arlen_m0, axi_arvalid_m0, axi_rready_m0,
      input  axi_araddr_m1, axi_arlen_m1, axi_arvalid_m1, axi_rready_m1
   );

endinterface

// File: rtl/axi_read_arbiter_rr_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request found
// scanning upward from the slot after the previous winner (wrapping at
// NUM_SLAVES) wins. Produces both one-hot and encoded grants.
module rr_arbiter #(
   parameter  int NUM_SLAVES = 3,
   localparam int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic [NUM_SLAVES-1:0] req_i,
   input  logic [IDX_W-1:0]      last_grant_i,
   output logic [NUM_SLAVES-1:0] grant_onehot_o,
   output logic [IDX_W-1:0]      grant_idx_o,
   output logic                  grant_valid_o
);

   // Rotating priority scan; earlier hits in the scan lock out later ones.
   always_comb begin
      int cand;
      cand           = 0;
      grant_onehot_o = '0;
      grant_idx_o    = '0;
      grant_valid_o  = 1'b0;
      for (int off = 1; off <= NUM_SLAVES; off++) begin
         cand = int'(last_grant_i) + off;
         cand = (cand >= NUM_SLAVES) ? (cand - NUM_SLAVES) : cand;
         if (!grant_valid_o && req_i[cand]) begin
            grant_valid_o        = 1'b1;
            grant_idx_o          = cand[IDX_W-1:0];
            grant_onehot_o[cand] = 1'b1;
         end else begin
            grant_valid_o = grant_valid_o;
         end
      end
   end

endmodule

// File: rtl/axi_read_arbiter_rr.sv
// Round-robin AXI read router: NUM_SLAVES requestors share two downstream
// read masters, split by address at M1_BASE_ADDRESS (master-1 addresses are
// rebased). One transaction is in flight at a time; RLAST toward the
// requestor is generated locally from ARLEN+1.
// Optional feature macro: AXI_RD_PERF_EN adds per-slave beat counters on
// output perf_beats.
module axi_read_arbiter_rr
   import axi_defs::*;
#(
   parameter int                        NUM_SLAVES      = 3,
   parameter int                        DATA_WIDTH      = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] M1_BASE_ADDRESS = M1_BASE_ADDRESS_DEFAULT
) (
   input logic                  clk,
   input logic                  reset,
   axi_read_arbiter_rr_if.slave bus
`ifdef AXI_RD_PERF_EN
   ,
   output logic [NUM_SLAVES*32-1:0] perf_beats
`endif
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int BEAT_W = AXI_LEN_WIDTH + 1;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          last_grant_q, last_grant_d;
   logic [NUM_SLAVES-1:0]     grant_oh_q, grant_oh_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_LEN_WIDTH-1:0]  len_q, len_d;
   logic [BEAT_W-1:0]         beats_left_q, beats_left_d;
   logic                      master_sel_q, master_sel_d;

   logic [NUM_SLAVES-1:0]     arb_onehot;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_valid;
   logic [AXI_ADDR_WIDTH-1:0] req_addr;
   logic [AXI_LEN_WIDTH-1:0]  req_len;

   logic                      sel_arready;
   logic                      sel_rvalid;
   logic [DATA_WIDTH-1:0]     sel_rdata;
   logic                      granted_rready;
   logic                      beat_hs;

   logic [NUM_SLAVES-1:0]     arready_s_c, rvalid_s_c, rlast_s_c;
   logic [DATA_WIDTH-1:0]     rdata_s_c;
   logic [AXI_ADDR_WIDTH-1:0] araddr_m0_c, araddr_m1_c;
   logic [AXI_LEN_WIDTH-1:0]  arlen_m0_c, arlen_m1_c;
   logic                      arvalid_m0_c, arvalid_m1_c, rready_m0_c, rready_m1_c;

   rr_arbiter #(.NUM_SLAVES(NUM_SLAVES)) u_rr_arbiter (
      .req_i          (bus.axi_arvalid_s),
      .last_grant_i   (last_grant_q),
      .grant_onehot_o (arb_onehot),
      .grant_idx_o    (arb_idx),
      .grant_valid_o  (arb_valid)
   );

   assign req_addr       = bus.axi_araddr_s[arb_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
   assign req_len        = bus.axi_arlen_s[arb_idx*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
   assign sel_arready    = master_sel_q ? bus.axi_arready_m1 : bus.axi_arready_m0;
   assign sel_rvalid     = master_sel_q ? bus.axi_rvalid_m1  : bus.axi_rvalid_m0;
   assign sel_rdata      = master_sel_q ? bus.axi_rdata_m1   : bus.axi_rdata_m0;
   assign granted_rready = |(bus.axi_rready_s & grant_oh_q);
   assign beat_hs        = (state_q == STATE_ACTIVE_BURST) && sel_rvalid && granted_rready;

   // Next-state and output decode; everything not owned by the granted
   // requestor / selected master stays at zero.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_oh_d   = grant_oh_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beats_left_d = beats_left_q;
      master_sel_d = master_sel_q;
      arready_s_c  = '0;
      rvalid_s_c   = '0;
      rlast_s_c    = '0;
      rdata_s_c    = '0;
      araddr_m0_c  = '0;
      araddr_m1_c  = '0;
      arlen_m0_c   = '0;
      arlen_m1_c   = '0;
      arvalid_m0_c = 1'b0;
      arvalid_m1_c = 1'b0;
      rready_m0_c  = 1'b0;
      rready_m1_c  = 1'b0;

      // Address and length stay on the selected master for the whole transaction.
      if (state_q != STATE_ARBITRATE) begin
         if (master_sel_q) begin
            araddr_m1_c = rebase_addr(addr_q, M1_BASE_ADDRESS);
            arlen_m1_c  = len_q;
         end else begin
            araddr_m0_c = addr_q;
            arlen_m0_c  = len_q;
         end
      end else begin
         araddr_m0_c = '0;
      end

      case (state_q)
         STATE_ARBITRATE: begin
            if (arb_valid) begin
               last_grant_d = arb_idx;
               grant_oh_d   = arb_onehot;
               addr_d       = req_addr;
               len_d        = req_len;
               beats_left_d = beats_from_len(req_len);
               master_sel_d = (req_addr >= M1_BASE_ADDRESS);
               state_d      = STATE_ISSUE_ADDRESS;
            end else begin
               state_d = STATE_ARBITRATE;
            end
         end
         STATE_ISSUE_ADDRESS: begin
            arvalid_m0_c = ~master_sel_q;
            arvalid_m1_c = master_sel_q;
            if (sel_arready) begin
               arready_s_c = grant_oh_q;
               state_d     = STATE_ACTIVE_BURST;
            end else begin
               state_d = STATE_ISSUE_ADDRESS;
            end
         end
         STATE_ACTIVE_BURST: begin
            rvalid_s_c  = sel_rvalid ? grant_oh_q : '0;
            rlast_s_c   = (sel_rvalid && (beats_left_q == 9'd1)) ? grant_oh_q : '0;
            rdata_s_c   = sel_rdata;
            rready_m0_c = ~master_sel_q & granted_rready;
            rready_m1_c = master_sel_q & granted_rready;
            if (beat_hs) begin
               beats_left_d = beats_left_q - 9'd1;
               state_d      = (beats_left_q == 9'd1) ? STATE_ARBITRATE : STATE_ACTIVE_BURST;
            end else begin
               state_d = STATE_ACTIVE_BURST;
            end
         end
         default: begin
            state_d = STATE_ARBITRATE;
         end
      endcase
   end

   // State and transaction registers; reset abandons any burst in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= STATE_ARBITRATE;
         last_grant_q <= IDX_W'(NUM_SLAVES - 1);
         grant_oh_q   <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         beats_left_q <= '0;
         master_sel_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_oh_q   <= grant_oh_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beats_left_q <= beats_left_d;
         master_sel_q <= master_sel_d;
      end
   end

   assign bus.axi_arready_s  = arready_s_c;
   assign bus.axi_rvalid_s   = rvalid_s_c;
   assign bus.axi_rlast_s    = rlast_s_c;
   assign bus.axi_rdata_s    = rdata_s_c;
   assign bus.axi_araddr_m0  = araddr_m0_c;
   assign bus.axi_araddr_m1  = araddr_m1_c;
   assign bus.axi_arlen_m0   = arlen_m0_c;
   assign bus.axi_arlen_m1   = arlen_m1_c;
   assign bus.axi_arvalid_m0 = arvalid_m0_c;
   assign bus.axi_arvalid_m1 = arvalid_m1_c;
   assign bus.axi_rready_m0  = rready_m0_c;
   assign bus.axi_rready_m1  = rready_m1_c;

`ifdef AXI_RD_PERF_EN
   logic [31:0] perf_q [NUM_SLAVES];

   // Free-running per-requestor count of completed beats (wraps at 2^32).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            perf_q[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (beat_hs && grant_oh_q[i]) begin
               perf_q[i] <= perf_q[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_perf
      assign perf_beats[g*32 +: 32] = perf_q[g];
   end
`endif

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Self-checking bench for axi_read_arbiter_rr: directed and randomized
// read transactions checked cycle by cycle against a transaction-level
// model (round-robin pick, address routing/rebase, beat counting).
module tb_axi_read_arbiter_rr;
   import axi_defs::*;

   localparam int          NS   = 3;
   localparam int          DW   = 32;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   axi_read_arbiter_rr_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) bus ();
`ifdef AXI_RD_PERF_EN
   logic [NS*32-1:0] perf_beats;
`endif

   axi_read_arbiter_rr #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .M1_BASE_ADDRESS(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef AXI_RD_PERF_EN
      , .perf_beats (perf_beats)
`endif
   );

   int          total = 0;
   int          bad   = 0;
   int          model_last;
   int unsigned perf_model [NS];
   logic [31:0] req_addr [NS];
   logic [7:0]  req_len  [NS];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NS-1:0] mask, input int last);
      for (int k = 1; k <= NS; k++) begin
         if (mask[(last + k) % NS]) return (last + k) % NS;
      end
      return -1;
   endfunction

   function automatic logic drive_mode(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 2) == 0;
         2:       return 1'($urandom_range(0, 1));
         default: return (cyc % 3) != 2;
      endcase
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom & 32'h0fff_fffc;
      return ($urandom_range(0, 1) == 1) ? (BASE + r) : r;
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
      req_addr[i] = a;
      req_len[i]  = l;
      bus.axi_araddr_s[i*32 +: 32] = a;
      bus.axi_arlen_s[i*8 +: 8]    = l;
      bus.axi_arvalid_s[i]         = 1'b1;
   endtask

   task automatic quiet();
      bus.axi_rvalid_m0  = 1'b0;
      bus.axi_rvalid_m1  = 1'b0;
      bus.axi_rdata_m0   = '0;
      bus.axi_rdata_m1   = '0;
      bus.axi_rready_s   = '0;
      bus.axi_arready_m0 = 1'b1;
      bus.axi_arready_m1 = 1'b1;
   endtask

   task automatic next_arb();
      @(negedge clk);
      quiet();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_arready_s"}, bus.axi_arready_s, 64'd0);
      check({tag, "_rvalid_s"}, bus.axi_rvalid_s, 64'd0);
      check({tag, "_rlast_s"}, bus.axi_rlast_s, 64'd0);
      check({tag, "_rdata_s"}, bus.axi_rdata_s, 64'd0);
      check({tag, "_araddr_m"}, {bus.axi_araddr_m1, bus.axi_araddr_m0}, 64'd0);
      check({tag, "_arlen_m"}, {bus.axi_arlen_m1, bus.axi_arlen_m0}, 64'd0);
      check({tag, "_ctl_m"}, {bus.axi_arvalid_m1, bus.axi_arvalid_m0,
                             bus.axi_rready_m1, bus.axi_rready_m0}, 64'd0);
   endtask

   // Called just after a negedge with requests presented for an ARBITRATE cycle.
   task automatic serve(input int g, input bit hold, input int rv_mode, input int rr_mode,
                        input int ar_stall, input int abort_after, input int glitch);
      logic [31:0] a;
      logic [7:0]  l;
      logic        sel, rv, rr;
      logic [31:0] d;
      int          remaining, cyc, hs_cnt;
      a = req_addr[g];
      l = req_len[g];
      sel = (a >= BASE);
      remaining = int'(l) + 1;
      #1;
      check("arb_arvalid_m", {bus.axi_arvalid_m1, bus.axi_arvalid_m0}, 64'd0);
      check("arb_arready_s", bus.axi_arready_s, 64'd0);
      check("arb_rvalid_s", bus.axi_rvalid_s, 64'd0);
      for (int s = 0; s <= ar_stall; s++) begin
         @(negedge clk);
         bus.axi_arready_m0 = (s == ar_stall);
         bus.axi_arready_m1 = (s == ar_stall);
         #1;
         check("issue_arvalid_m", {bus.axi_arvalid_m1, bus.axi_arvalid_m0}, sel ? 64'd2 : 64'd1);
         check("issue_araddr_m0", bus.axi_araddr_m0, sel ? 64'd0 : 64'(a));
         check("issue_araddr_m1", bus.axi_araddr_m1, sel ? 64'(a - BASE) : 64'd0);
         check("issue_arlen", sel ? bus.axi_arlen_m1 : bus.axi_arlen_m0, 64'(l));
         check("issue_arready_s", bus.axi_arready_s, (s == ar_stall) ? (64'd1 << g) : 64'd0);
      end
      hs_cnt = 0;
      cyc = 0;
      while (remaining > 0 && cyc < 3000) begin
         @(negedge clk);
         bus.axi_arready_m0 = 1'b1;
         bus.axi_arready_m1 = 1'b1;
         if (!hold) bus.axi_arvalid_s[g] = 1'b0;
         if (glitch >= 0) bus.axi_arvalid_s[glitch] = (cyc == 0);
         rv = drive_mode(rv_mode, cyc);
         rr = drive_mode(rr_mode, cyc);
         d  = $urandom;
         bus.axi_rready_s    = NS'($urandom);
         bus.axi_rready_s[g] = rr;
         if (sel) begin
            bus.axi_rvalid_m1 = rv; bus.axi_rdata_m1 = d;
            bus.axi_rvalid_m0 = 1'($urandom_range(0, 1)); bus.axi_rdata_m0 = $urandom;
         end else begin
            bus.axi_rvalid_m0 = rv; bus.axi_rdata_m0 = d;
            bus.axi_rvalid_m1 = 1'($urandom_range(0, 1)); bus.axi_rdata_m1 = $urandom;
         end
         #1;
         check("data_rvalid_s", bus.axi_rvalid_s, rv ? (64'd1 << g) : 64'd0);
         check("data_rlast_s", bus.axi_rlast_s, (rv && remaining == 1) ? (64'd1 << g) : 64'd0);
         check("data_rready_m", {bus.axi_rready_m1, bus.axi_rready_m0},
               rr ? (sel ? 64'd2 : 64'd1) : 64'd0);
         check("data_ar_quiet", {bus.axi_arready_s, bus.axi_arvalid_m1, bus.axi_arvalid_m0}, 64'd0);
         if (rv) check("data_rdata_s", bus.axi_rdata_s, 64'(d));
         if (rv && rr) begin
            remaining--;
            hs_cnt++;
            perf_model[g]++;
         end
         cyc++;
         if (abort_after > 0 && hs_cnt == abort_after) break;
      end
      if (abort_after == 0) check("burst_beats_left", 64'(remaining), 64'd0);
   endtask

   task automatic pick_serve(input bit hold, input int rv_mode, input int rr_mode,
                             input int ar_stall, input int abort_after, input int glitch);
      int g;
      g = rr_pick(bus.axi_arvalid_s, model_last);
      model_last = g;
      serve(g, hold, rv_mode, rr_mode, ar_stall, abort_after, glitch);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      bus.axi_araddr_s  = '0;
      bus.axi_arlen_s   = '0;
      bus.axi_arvalid_s = '0;
      quiet();
      for (int i = 0; i < NS; i++) begin
         perf_model[i] = 0;
         req_addr[i]   = '0;
         req_len[i]    = '0;
      end
      model_last = NS - 1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
`ifdef AXI_RD_PERF_EN
      check("reset_perf", 64'(perf_beats), 64'd0);
`endif
      reset = 1'b0;

      // single burst to m0
      next_arb();
      set_req(0, 32'h0000_1000, 8'd3);
      pick_serve(1'b0, 0, 0, 0, 0, -1);
      next_arb();
      #1;
      check_all_zero("idle_after_single");

      // rebase to m1, single beat
      set_req(1, 32'h1000_0040, 8'd0);
      pick_serve(1'b0, 0, 0, 0, 0, -1);

      // address boundaries: base-4 to m0, exactly base to m1 at offset 0
      next_arb();
      set_req(0, BASE - 32'd4, 8'd0);
      pick_serve(1'b0, 0, 0, 1, 0, -1);
      next_arb();
      set_req(2, BASE, 8'd0);
      pick_serve(1'b0, 0, 0, 0, 0, -1);

      // fairness: all hold requests, zero-latency memory
      next_arb();
      for (int i = 0; i < NS; i++) set_req(i, rand_addr(), 8'd1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) next_arb();
         pick_serve(1'b1, 0, 0, 0, 0, -1);
      end
      next_arb();
      bus.axi_arvalid_s = '0;

      // single requestor re-granted back-to-back
      set_req(1, rand_addr(), 8'd2);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) next_arb();
         pick_serve(1'b1, 0, 0, 0, 0, -1);
      end
      next_arb();
      bus.axi_arvalid_s = '0;

      // backpressure on both sides, arlen 7, stalled address
      set_req(2, 32'h0000_2000, 8'd7);
      pick_serve(1'b0, 3, 1, 2, 0, -1);

      // slave 1 raises and drops arvalid during a burst; never served
      next_arb();
      set_req(0, 32'h0000_3000, 8'd3);
      pick_serve(1'b0, 0, 0, 0, 0, 1);
      next_arb();
      set_req(2, rand_addr(), 8'd1);
      pick_serve(1'b0, 0, 0, 0, 0, -1);

      // randomized traffic
      for (int t = 0; t < 20; t++) begin
         next_arb();
         for (int i = 0; i < NS; i++) begin
            if (!bus.axi_arvalid_s[i] && $urandom_range(0, 1) == 1)
               set_req(i, rand_addr(), 8'($urandom_range(0, 15)));
         end
         if (bus.axi_arvalid_s == '0) set_req(t % NS, rand_addr(), 8'd2);
         pick_serve(1'b0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1), 0, -1);
      end
      next_arb();
      bus.axi_arvalid_s = '0;

      // maximum length
      set_req(0, rand_addr(), 8'd255);
      pick_serve(1'b0, 0, 0, 0, 0, -1);

`ifdef AXI_RD_PERF_EN
      for (int i = 0; i < NS; i++) check("perf_beats", 64'(perf_beats[i*32 +: 32]), 64'(perf_model[i]));
`endif

      // reset after beat 2 of 4
      next_arb();
      set_req(1, rand_addr(), 8'd3);
      pick_serve(1'b0, 0, 0, 0, 2, -1);
      @(negedge clk);
      reset = 1'b1;
      bus.axi_rvalid_m0 = 1'b1;
      bus.axi_rvalid_m1 = 1'b1;
      bus.axi_rready_s  = '1;
      @(negedge clk);
      #1;
      check_all_zero("reset_mid");
`ifdef AXI_RD_PERF_EN
      check("reset_mid_perf", 64'(perf_beats), 64'd0);
`endif
      reset = 1'b0;
      model_last = NS - 1;
      for (int i = 0; i < NS; i++) perf_model[i] = 0;
      next_arb();
      set_req(2, 32'h0000_4000, 8'd1);
      pick_serve(1'b0, 0, 0, 0, 0, -1);
`ifdef AXI_RD_PERF_EN
      next_arb();
      #1;
      for (int i = 0; i < NS; i++) check("perf_after_reset", 64'(perf_beats[i*32 +: 32]), 64'(perf_model[i]));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter_rr.md
Name: axi_read_arbiter_rr

Overview:
- Parametrised read-channel router: NUM_SLAVES requestor ports (CPU/L2, display, future DMA) share two downstream AXI read master interfaces.
- Targets are split by address at M1_BASE_ADDRESS.
- Arbitration is round-robin instead of fixed priority.
- The beat count is AXI-correct (ARLEN+1), and the block generates RLAST toward each requestor.

Parameters:
- NUM_SLAVES, 3, number of requestor ports (2..8).
- DATA_WIDTH, 32, read data width.
- M1_BASE_ADDRESS, 32'h10000000, first address routed to master 1; forwarded address is rebased by subtracting it.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- axi_araddr_s  in  NUM_SLAVES*32  requestor addresses, slave i at [i*32+:32].
- axi_arlen_s  in  NUM_SLAVES*8  requestor burst lengths (beats-1).
- axi_arvalid_s  in  NUM_SLAVES  address valid.
- axi_arready_s  out  NUM_SLAVES  address accepted.
- axi_rready_s  in  NUM_SLAVES  requestor data ready.
- axi_rvalid_s  out  NUM_SLAVES  data valid.
- axi_rlast_s  out  NUM_SLAVES  final beat.
- axi_rdata_s  out  DATA_WIDTH  shared read data, valid only for the granted slave.
- axi_araddr_m0/m1  out  32  downstream address.
- axi_arlen_m0/m1  out  8  downstream length.
- axi_arvalid_m0/m1  out  1  downstream address valid.
- axi_arready_m0/m1  in  1  downstream address accepted.
- axi_rvalid_m0/m1  in  1  downstream data valid.
- axi_rready_m0/m1  out  1  downstream data ready.
- axi_rdata_m0/m1  in  DATA_WIDTH  downstream data.

Behaviour:
- FSM states: ARBITRATE(0), ISSUE_ADDRESS(1), ACTIVE_BURST(2).
- ARBITRATE, no request: stay in ARBITRATE.
- ARBITRATE, any axi_arvalid_s set:
  - Grant the first asserted index scanning upward from last_grant+1, modulo NUM_SLAVES.
  - Latch address and ARLEN; set beats_left = ARLEN+1 (9-bit counter, no 8-bit overflow).
  - Set master_sel = (addr >= M1_BASE_ADDRESS); set last_grant = grant.
  - Go to ISSUE_ADDRESS.
- ISSUE_ADDRESS:
  - axi_arvalid_m[master_sel]=1.
  - araddr_m0 = latched address; araddr_m1 = latched address - M1_BASE_ADDRESS.
  - arlen_m = latched ARLEN, held stable for the whole transaction.
  - When the selected arready_m is high, axi_arready_s[grant] pulses combinationally in that same cycle, and the FSM moves to ACTIVE_BURST.
  - Latency: arvalid_s seen at cycle N gives arvalid_m at N+1, and arready_s in the same cycle as arready_m.
- ACTIVE_BURST:
  - rvalid_s[grant] = rvalid_m[sel]; rready_m[sel] = rready_s[grant]; rdata_s = rdata_m[sel].
  - Each handshake (rvalid && rready) decrements beats_left.
  - rlast_s[grant] = rvalid_s[grant] && beats_left==1.
  - The handshake at beats_left==1 returns the FSM to ARBITRATE.
- All ungranted outputs are 0. In ARBITRATE every arready_s, rvalid_s, rready_m and arvalid_m is 0.
- Arbitration boundaries:
  - A requestor that deasserts arvalid_s before grant is not served.
  - A new burst starts at the earliest one cycle after the last beat (one idle ARBITRATE cycle).
  - All requesting simultaneously: grants rotate 0,1,2,0,...
  - A single requestor is re-granted back-to-back.
- Address boundaries:
  - Address exactly M1_BASE_ADDRESS routes to m1 with araddr_m1=0.
  - Address M1_BASE_ADDRESS-4 routes to m0.
- Reset:
  - FSM=ARBITRATE; last_grant=NUM_SLAVES-1, so slave 0 wins the first tie.
  - Latched address, length and beats_left = 0; master_sel = 0.
  - All outputs 0.
  - Reset mid-burst abandons the burst and does not drain it; downstream recovery is the system's responsibility (shared reset).

Optional Feature:
- AXI_RD_PERF_EN defined:
  - Adds output perf_beats, NUM_SLAVES*32 bits: per-slave count of completed read beats.
  - Counters are free-running and wrap at 2^32; reset to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (axi_defs) holds:
  - State encodings STATE_ARBITRATE/ISSUE_ADDRESS/ACTIVE_BURST.
  - AXI_ADDR_WIDTH=32 and AXI_LEN_WIDTH=8.
  - The default M1 base constant.
- Sub-module rr_arbiter: NUM_SLAVES request vector plus last_grant in; one-hot grant and encoded index out; purely combinational, instantiated once.

Test Plan:
- Single burst: slave 0 requests addr 0x00001000, arlen 3 → arvalid_m0 next cycle; 4 beats forwarded; rlast_s[0] on beat 4; FSM idle after.
- Rebase: slave 1 requests 0x10000040, arlen 0 → araddr_m1=0x40; exactly one beat with rlast.
- Fairness: all three slaves hold arvalid, arlen 1, zero-latency memory → grant order 0,1,2,0,1,2; each burst 2 beats.
- Backpressure: rready_s toggles 1,0,1,0 and rvalid_m toggles during an arlen 7 burst → exactly 8 counted beats; rlast only on the 8th handshake.
- Max length: arlen 255 → 256 beats; no early exit.
- Reset mid-burst: assert reset after beat 2 of 4 → all outputs 0 next cycle; next request from slave 2 granted normally; with AXI_RD_PERF_EN, perf_beats reads 0.
